var_delay: RTL

Programmable, multi-channel delay line with a per-sample valid flag. It generalises the fixed delay stage: the delay is selectable at run time (1..MAX_DEL), several channels share one pointer set, and there is a clock enable for stalls. A delay change flushes the pipeline, and a busy flag covers the refill. It sits in the VGA/printer pixel path wherever a data bus must be re-aligned to sync signals by an amount that is only known at run time.

---
 rtl/var_delay_pkg.sv | 29 ++
 rtl/var_delay_mem.sv | 28 ++
 rtl/var_delay.sv | 125 ++++++++++++
 3 files changed

// File: rtl/var_delay_pkg.sv
// Shared types and helpers for the programmable delay line (var_delay).
// Latency: n/a (package only: fill FSM state type, width and clamp helpers).
// Backpressure: n/a.
package var_delay_pkg;

  // Fill FSM: FILL while the line refills after reset/load, RUN afterwards.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width needed to hold a delay value 0..max_del.
  function automatic int calc_dw(input int max_del);
    return $clog2(max_del + 1);
  endfunction

  // Address width for max_del entries; never below 1 bit.
  function automatic int calc_aw(input int max_del);
    return (max_del > 1) ? $clog2(max_del) : 1;
  endfunction

  // Map a requested delay onto the legal range 1..max_del.
  function automatic int clamp_del(input int sel, input int max_del);
    if (sel == 0) return 1;
    if (sel > max_del) return max_del;
    return sel;
  endfunction

endpackage

// File: rtl/var_delay_mem.sv
// Data storage for var_delay: DEPTH words, one shared read/write address.
// Latency: 1 cycle; rdata returns the old word at addr on the write cycle.
// Backpressure: none; rdata only updates when we=1, so it holds through stalls.
module var_delay_mem
  import var_delay_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = calc_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write on the same address; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/var_delay.sv
// Programmable multi-channel delay line (1..MAX_DEL) with valid flag; macro VAR_DELAY_MASK_EN zeroes dout while invalid.
// Latency: exactly cur_del enabled cycles; load flushes valids and refills (busy) for cur_del enabled cycles.
// Backpressure: en=0 freezes all state; no ready signalling, load takes effect regardless of en.
module var_delay
  import var_delay_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int MAX_DEL  = 16,
  parameter int DEF_DEL  = 4,
  localparam int DW      = calc_dw(MAX_DEL)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [DW-1:0]             del_sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic [DW-1:0]             cur_del
);

  localparam int AW  = calc_aw(MAX_DEL);
  localparam int DWD = CHANNELS * WIDTH;

  logic [DW-1:0]      cur_del_q;
  logic [AW-1:0]      wp_q;
  logic [DW-1:0]      fill_cnt_q;
  state_e             state_q;
  logic [MAX_DEL-1:0] vld_q;
  logic               dout_valid_q;
  logic [DWD-1:0]     mem_rdata;

  logic          adv;
  logic [DW-1:0] sel_clamped;
  logic [DW-1:0] wp_last;
  logic [AW-1:0] wp_nxt;

  assign adv         = en & ~load;
  assign sel_clamped = DW'(clamp_del(int'(del_sel), MAX_DEL));
  assign wp_last     = cur_del_q - DW'(1);
  assign wp_nxt      = (DW'(wp_q) == wp_last) ? '0 : wp_q + AW'(1);

  // Delay register and circular write pointer; load restarts the pointer at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_del_q <= DW'(DEF_DEL);
      wp_q      <= '0;
    end else if (load) begin
      cur_del_q <= sel_clamped;
      wp_q      <= '0;
    end else if (en) begin
      wp_q      <= wp_nxt;
    end
  end

  // Fill FSM: count down cur_del enabled cycles after reset/load, then RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= DW'(DEF_DEL);
    end else if (load) begin
      state_q    <= FILL;
      fill_cnt_q <= sel_clamped;
    end else if (adv && state_q == FILL) begin
      if (fill_cnt_q == DW'(1)) begin
        state_q <= RUN;
      end
      fill_cnt_q <= fill_cnt_q - DW'(1);
    end
  end

  // Valid bits live here (not in the RAM) so a load can clear them in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      dout_valid_q <= 1'b0;
    end else if (load) begin
      vld_q        <= '0;
      dout_valid_q <= 1'b0;
    end else if (en) begin
      dout_valid_q <= vld_q[wp_q];
      vld_q[wp_q]  <= din_valid;
    end
  end

  var_delay_mem #(
    .DATA_W (DWD),
    .DEPTH  (MAX_DEL),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (adv),
    .addr  (wp_q),
    .wdata (din),
    .rdata (mem_rdata)
  );

`ifdef VAR_DELAY_MASK_EN
  // Gate the RAM output register with the registered valid: flop-to-output only.
  assign dout = dout_valid_q ? mem_rdata : '0;
`else
  // The RAM output flop has no reset, so hold dout at 0 until the first read.
  logic dout_clr_q;

  // Set by reset, cleared by the first enabled read; load does not disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_clr_q <= 1'b1;
    end else if (adv) begin
      dout_clr_q <= 1'b0;
    end
  end

  assign dout = dout_clr_q ? '0 : mem_rdata;
`endif

  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == FILL);
  assign cur_del    = cur_del_q;

endmodule
